// File: rtl/map_gen_ctrl_pkg.sv
// Shared constants and types for the tile-map generator: map geometry,
// LFSR polynomial, spawn-cell coordinates and the controller state encoding.
package map_pkg;

    localparam int CELLS_X    = 32;
    localparam int CELLS_Y    = 24;
    localparam int MAP_ADDR_W = $clog2(CELLS_X * CELLS_Y);

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } cell_xy_t;

    // Player spawn area, always left free so the level is enterable.
    localparam int N_SPAWN = 3;
    localparam cell_xy_t SPAWN_CELLS [N_SPAWN] = '{
        '{x: 8'd1, y: 8'd1},
        '{x: 8'd2, y: 8'd1},
        '{x: 8'd1, y: 8'd2}
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        FILL,
        DONE
    } map_gen_state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/map_gen_ctrl_if.sv
// Bundle between game logic / VGA timing / map RAM write port and the
// generator. The generator is the master of the RAM write strobe.
interface map_gen_ctrl_if;
    import map_pkg::*;

    logic                  start;
    logic                  seed_load;
    logic [15:0]           seed_in;
    logic                  vblnk;
    logic                  busy;
    logic                  done;
    logic                  wr_en;
    logic [MAP_ADDR_W-1:0] wr_addr;
    logic                  wr_data;

    modport master (
        input  start, seed_load, seed_in, vblnk,
        output busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, seed_load, seed_in, vblnk,
        input  busy, done, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/map_gen_ctrl_lfsr16.sv
// 16-bit Galois LFSR with synchronous load; load wins over advance.
module lfsr16
    import map_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    logic [15:0] lfsr_q, lfsr_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load)    lfsr_d = load_val;
        else if (en) lfsr_d = lfsr_next(lfsr_q);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/map_gen_ctrl.sv
// Fills the tile-occupancy map with a pseudo-random wall layout, one cell
// per clock, writing only during vertical blanking.
module map_gen_ctrl #(
    parameter int          CELLS_X     = map_pkg::CELLS_X,
    parameter int          CELLS_Y     = map_pkg::CELLS_Y,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [8:0]  FILL_THRESH = 9'd64
) (
    input  logic           clk,
    input  logic           rst,
    map_gen_ctrl_if.master bus
);
    import map_pkg::*;

    localparam int XW = $clog2(CELLS_X);
    localparam int YW = $clog2(CELLS_Y);

    map_gen_state_t        state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_en_q, wr_en_d;
    logic [MAP_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;

    logic [15:0]           lfsr_val;
    logic                  issue;
    logic                  last_cell;
    logic                  is_border;
    logic                  is_spawn;
    logic                  cell_wall;
    logic [MAP_ADDR_W-1:0] cell_addr;

    assign issue     = (state_q == FILL) && bus.vblnk;
    assign last_cell = (x_q == XW'(CELLS_X - 1)) && (y_q == YW'(CELLS_Y - 1));
    assign cell_addr = MAP_ADDR_W'(y_q) * MAP_ADDR_W'(CELLS_X) + MAP_ADDR_W'(x_q);

    // Advances once per issued cell, border and spawn cells included.
    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (issue),
        .load     ((state_q == IDLE) && bus.seed_load),
        .load_val ((bus.seed_in == 16'd0) ? SEED : bus.seed_in),
        .q        (lfsr_val)
    );

    always_comb begin
        is_border = (x_q == '0) || (x_q == XW'(CELLS_X - 1)) ||
                    (y_q == '0) || (y_q == YW'(CELLS_Y - 1));
        is_spawn  = 1'b0;
        for (int i = 0; i < N_SPAWN; i++) begin
            if ((8'(x_q) == SPAWN_CELLS[i].x) && (8'(y_q) == SPAWN_CELLS[i].y))
                is_spawn = 1'b1;
        end
        cell_wall = is_border ? 1'b1 :
                    is_spawn  ? 1'b0 :
                    ({1'b0, lfsr_val[7:0]} < FILL_THRESH);
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = WAIT_VB;
            WAIT_VB: if (bus.vblnk) state_d = FILL;
            FILL: begin
                if (bus.vblnk) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cell_addr;
                    wr_data_d = cell_wall;
                    if (x_q == XW'(CELLS_X - 1)) begin
                        x_d = '0;
                        y_d = (y_q == YW'(CELLS_Y - 1)) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_cell) state_d = DONE;
                end else begin
                    state_d = WAIT_VB;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Busy covers DONE so it drops together with the done pulse.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_map_gen_ctrl.sv
// Three generators (FILL_THRESH 64, 0, 256) share stimulus; a reference model
// pushes expected writes into per-instance queues that a monitor pops.
module tb_map_gen_ctrl;

    localparam logic [15:0] SEED_DEF = 16'hACE1;

    typedef struct packed {
        logic [9:0] addr;
        logic       data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, seed_load, vblnk;
    logic [15:0] seed_in;

    logic        obs_en   [3];
    logic        obs_data [3];
    logic        obs_busy [3];
    logic        obs_done [3];
    logic [9:0]  obs_addr [3];

    wr_t         exp_q [3][$];
    int          n_wr  [3];
    int          n_one [3];
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    logic [15:0] model_lfsr;
    logic        prev_en   = 1'b0;
    logic [9:0]  prev_addr = '0;
    logic        vb_prev   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        map_gen_ctrl_if ifc ();
        assign ifc.start     = start;
        assign ifc.seed_load = seed_load;
        assign ifc.seed_in   = seed_in;
        assign ifc.vblnk     = vblnk;
        map_gen_ctrl #(
            .FILL_THRESH((g == 0) ? 9'd64 : (g == 1) ? 9'd0 : 9'd256)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
        assign obs_en[g]   = ifc.wr_en;
        assign obs_data[g] = ifc.wr_data;
        assign obs_busy[g] = ifc.busy;
        assign obs_done[g] = ifc.done;
        assign obs_addr[g] = ifc.wr_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic model_cell(input int x, input int y, input logic [15:0] s, input int thr);
        if (x == 0 || x == 31 || y == 0 || y == 23) return 1'b1;
        if ((x == 1 && y == 1) || (x == 2 && y == 1) || (x == 1 && y == 2)) return 1'b0;
        return int'(s[7:0]) < thr;
    endfunction

    task automatic push_expected();
        logic [15:0] s;
        int thr [3];
        thr = '{64, 0, 256};
        s = model_lfsr;
        for (int g = 0; g < 3; g++) begin
            n_wr[g]  = 0;
            n_one[g] = 0;
        end
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 32; x++) begin
                for (int g = 0; g < 3; g++)
                    exp_q[g].push_back('{addr: 10'(y * 32 + x), data: model_cell(x, y, s, thr[g])});
                s = model_step(s);
            end
        end
        model_lfsr = s;
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_busy"},    obs_busy[0], 0);
        check({tag, "_done"},    obs_done[0], 0);
        check({tag, "_wr_en"},   obs_en[0],   0);
        check({tag, "_wr_addr"}, obs_addr[0], 0);
        check({tag, "_wr_data"}, obs_data[0], 0);
    endtask

    // load_mode: 0 none, 1 seed_load the cycle before start, 2 together with start.
    task automatic run_gen(input int load_mode, input logic [15:0] sd, input bit pause,
                           input bit extra_start, input int abort_at);
        bit done_seen = 1'b0;
        bit aborted   = 1'b0;
        int first_cyc = -1;
        int done_cyc  = -1;
        if (load_mode != 0) model_lfsr = (sd == 16'd0) ? SEED_DEF : sd;
        vblnk = 1'b1;
        if (load_mode == 1) begin
            seed_in = sd;
            seed_load = 1'b1;
            @(posedge clk); #1;
            seed_load = 1'b0;
        end
        push_expected();
        start = 1'b1;
        if (load_mode == 2) begin
            seed_in = sd;
            seed_load = 1'b1;
        end
        check("busy_before_start", obs_busy[0], 0);
        @(posedge clk); #1;
        start = 1'b0;
        seed_load = 1'b0;
        check("busy_rise", obs_busy[0], 1);
        for (int cyc = 0; cyc < 4000 && !done_seen && !aborted; cyc++) begin
            vblnk = pause ? ((cyc % 80) < 50) : 1'b1;
            start = extra_start && (cyc == 200);
            @(posedge clk); #1;
            if (!pause && cyc == 0) check("first_wr_lat_early", obs_en[0], 0);
            if (!pause && cyc == 1) check("first_wr_lat", obs_en[0], 1);
            if (obs_en[0] && first_cyc < 0) first_cyc = cyc;
            if (obs_done[0]) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (abort_at >= 0 && obs_en[0] && int'(obs_addr[0]) == abort_at) begin
                #2 rst = 1'b1;
                #1 check_outputs_clear("abort");
                for (int g = 0; g < 3; g++) exp_q[g].delete();
                model_lfsr = SEED_DEF;
                aborted = 1'b1;
            end
        end
        start = 1'b0;
        vblnk = 1'b1;
        if (aborted) begin
            @(posedge clk); #1;
            check_outputs_clear("abort_hold");
            rst = 1'b0;
            return;
        end
        check("done_seen", done_seen, 1);
        if (!pause) check("write_span", done_cyc - first_cyc, 768);
        repeat (20) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("sb_drained", exp_q[g].size(), 0);
            check("write_count", n_wr[g], 768);
        end
        check("thr0_walls", n_one[1], 108);
        check("thr256_walls", n_one[2], 765);
        check("busy_after", obs_busy[0], 0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (obs_en[g]) begin
                    check("sb_avail", 32'(exp_q[g].size() != 0), 1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        check("wr_addr", obs_addr[g], e.addr);
                        check("wr_data", obs_data[g], e.data);
                    end
                    n_wr[g]++;
                    if (obs_data[g]) n_one[g]++;
                end
            end
            if (obs_en[0]) check("wr_in_vblnk", vb_prev, 1);
            check("done_timing", obs_done[0], prev_en && (prev_addr == 10'd767));
            if (obs_done[0]) check("busy_at_done", obs_busy[0], 0);
        end
        prev_en   <= obs_en[0];
        prev_addr <= obs_addr[0];
        vb_prev   <= vblnk;
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        seed_load = 1'b0;
        seed_in = 16'h0000;
        vblnk = 1'b0;
        model_lfsr = SEED_DEF;

        // Asynchronous reset between clock edges clears outputs at once.
        #2 rst = 1'b1;
        #1 check_outputs_clear("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle with vblnk high and no start: no writes.
        vblnk = 1'b1;
        for (int g = 0; g < 3; g++) n_wr[g] = 0;
        repeat (100) @(posedge clk);
        #1;
        check("idle_no_writes", n_wr[0], 0);
        check("idle_busy", obs_busy[0], 0);

        // Reset seed, vblnk held high.
        run_gen(0, 16'h0000, 1'b0, 1'b0, -1);
        // seed_in = 0 falls back to SEED; paused 50/30 must give the same data.
        run_gen(1, 16'h0000, 1'b1, 1'b0, -1);
        // Explicit seed, extra start mid-run is ignored.
        run_gen(1, 16'h1234, 1'b0, 1'b1, -1);
        // Seed loaded in the same cycle as start.
        run_gen(2, 16'h1234, 1'b0, 1'b0, -1);
        // Abort with reset at address 100, then restart from SEED.
        run_gen(0, 16'h0000, 1'b0, 1'b0, 100);
        run_gen(0, 16'h0000, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
